// File: rtl/ram_ctrl_pkg.sv
// Shared definitions for the 8x16 RAM arbiter/sequencer.
//   ST_*      : FSM state encodings (INIT sweep, IDLE arbitration, ACCESS)
//   DEPTH     : number of RAM words
//   REQ_A/B   : requester ids used for winner / last-winner tracking
package ram_ctrl_pkg;
  localparam logic [1:0] ST_INIT   = 2'd0;
  localparam logic [1:0] ST_IDLE   = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;

  localparam int DEPTH = 8;

  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;

  typedef enum logic [1:0] {
    S_INIT   = ST_INIT,
    S_IDLE   = ST_IDLE,
    S_ACCESS = ST_ACCESS
  } state_t;
endpackage

// File: rtl/ram8x16_arbiter_rr_arb2.sv
// rr_arb2: combinational 2-way winner select.
//   i_req_a, i_req_b : pending requests
//   i_last           : id of previous winner (round-robin build only)
//   o_any            : at least one request pending
//   o_win            : winning requester id (REQ_A / REQ_B)
// Build option RAM_ARB_FIXED_PRIO_EN: A wins every tie and i_last is dropped.
import ram_ctrl_pkg::*;

module rr_arb2 (
  input  logic i_req_a,
  input  logic i_req_b,
`ifndef RAM_ARB_FIXED_PRIO_EN
  input  logic i_last,
`endif
  output logic o_any,
  output logic o_win
);
  always_comb begin
    o_any = i_req_a | i_req_b;
`ifdef RAM_ARB_FIXED_PRIO_EN
    o_win = i_req_a ? REQ_A : REQ_B;
`else
    // On a tie the requester that did not win last time goes next.
    if (i_req_a && i_req_b) o_win = ~i_last;
    else                    o_win = i_req_a ? REQ_A : REQ_B;
`endif
  end
endmodule

// File: rtl/ram8x16_arbiter.sv
// ram8x16_arbiter: zero-fills the RAM after reset, then serialises single-word
// read/write requests from requesters A and B onto the RAM pins.
//   clk, clr             : clock, synchronous active-low reset
//   req/we/addr/wdata_x  : requester x command (held until gnt_x)
//   gnt_x                : x's access is on the RAM this cycle
//   rvalid_x, rdata_x    : read result pulse / held read data
//   init_done            : zero-fill sweep finished
//   ram_rw/addr/din/dout : RAM interface (rw=1 write)
// Build option RAM_ARB_FIXED_PRIO_EN: fixed A-first priority on ties.
// Note: reset lands the FSM in INIT, and INIT is the write sweep, so ram_rw
// is already high in the cycle following a reset edge (addr/din are 0).
import ram_ctrl_pkg::*;

module ram8x16_arbiter #(
  parameter int DW = 16,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          req_a,
  input  logic          we_a,
  input  logic [AW-1:0] addr_a,
  input  logic [DW-1:0] wdata_a,
  output logic          gnt_a,
  output logic          rvalid_a,
  output logic [DW-1:0] rdata_a,
  input  logic          req_b,
  input  logic          we_b,
  input  logic [AW-1:0] addr_b,
  input  logic [DW-1:0] wdata_b,
  output logic          gnt_b,
  output logic          rvalid_b,
  output logic [DW-1:0] rdata_b,
  output logic          init_done,
  output logic          ram_rw,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout
);
  state_t        r_state, w_state_nxt;
  logic [AW-1:0] r_cnt;
  logic          r_we, r_win;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic          r_init_done, r_rvalid_a, r_rvalid_b;
  logic [DW-1:0] r_rdata_a, r_rdata_b;
  logic          w_any, w_win;
`ifndef RAM_ARB_FIXED_PRIO_EN
  logic          r_last;
`endif

  rr_arb2 u_arb (
    .i_req_a (req_a),
    .i_req_b (req_b),
`ifndef RAM_ARB_FIXED_PRIO_EN
    .i_last  (r_last),
`endif
    .o_any   (w_any),
    .o_win   (w_win)
  );

  always_ff @(posedge clk) begin
    if (!clr) r_state <= S_INIT;
    else      r_state <= w_state_nxt;
  end

  // In IDLE the RAM pins keep showing the last command (r_addr/r_wdata);
  // during the sweep those registers track the sweep so the hold is seamless.
  always_comb begin
    w_state_nxt = r_state;
    ram_rw      = 1'b0;
    ram_addr    = r_addr;
    ram_din     = r_wdata;
    gnt_a       = 1'b0;
    gnt_b       = 1'b0;
    case (r_state)
      S_INIT: begin
        ram_rw   = 1'b1;
        ram_addr = r_cnt;
        ram_din  = '0;
        if (r_cnt == {AW{1'b1}}) w_state_nxt = S_IDLE;
      end
      S_IDLE: begin
        if (w_any) w_state_nxt = S_ACCESS;
      end
      S_ACCESS: begin
        ram_rw      = r_we;
        gnt_a       = (r_win == REQ_A);
        gnt_b       = (r_win == REQ_B);
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      r_cnt       <= '0;
      r_we        <= 1'b0;
      r_win       <= REQ_A;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_init_done <= 1'b0;
      r_rvalid_a  <= 1'b0;
      r_rvalid_b  <= 1'b0;
      r_rdata_a   <= '0;
      r_rdata_b   <= '0;
`ifndef RAM_ARB_FIXED_PRIO_EN
      r_last      <= REQ_B;
`endif
    end else begin
      r_rvalid_a <= 1'b0;
      r_rvalid_b <= 1'b0;
      case (r_state)
        S_INIT: begin
          r_cnt   <= r_cnt + 1'b1;
          r_addr  <= r_cnt;
          r_wdata <= '0;
          if (r_cnt == {AW{1'b1}}) r_init_done <= 1'b1;
        end
        S_IDLE: begin
          if (w_any) begin
            r_win <= w_win;
`ifndef RAM_ARB_FIXED_PRIO_EN
            r_last <= w_win;
`endif
            if (w_win == REQ_A) begin
              r_we <= we_a; r_addr <= addr_a; r_wdata <= wdata_a;
            end else begin
              r_we <= we_b; r_addr <= addr_b; r_wdata <= wdata_b;
            end
          end
        end
        S_ACCESS: begin
          // RAM read data is valid while the read address is driven.
          if (!r_we) begin
            if (r_win == REQ_A) begin
              r_rdata_a <= ram_dout; r_rvalid_a <= 1'b1;
            end else begin
              r_rdata_b <= ram_dout; r_rvalid_b <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign init_done = r_init_done;
  assign rvalid_a  = r_rvalid_a;
  assign rvalid_b  = r_rvalid_b;
  assign rdata_a   = r_rdata_a;
  assign rdata_b   = r_rdata_b;
endmodule

// File: tb/tb_ram8x16_arbiter.sv
// Self-checking bench for ram8x16_arbiter with a behavioural RAM model.
// Stimulus drives requests and, on each grant, pushes the expected read data
// (from a plain array memory model) into per-requester queues; a monitor pops
// and compares whenever rvalid is seen.
import ram_ctrl_pkg::*;

module tb_ram8x16_arbiter;
  logic        clk = 1'b0;
  logic        clr = 1'b0;
  logic        req_a = 0, we_a = 0, req_b = 0, we_b = 0;
  logic [2:0]  addr_a = 0, addr_b = 0;
  logic [15:0] wdata_a = 0, wdata_b = 0;
  logic        gnt_a, gnt_b, rvalid_a, rvalid_b, init_done, ram_rw;
  logic [15:0] rdata_a, rdata_b, ram_din, ram_dout;
  logic [2:0]  ram_addr;

  int n_checks = 0;
  int n_fail   = 0;

  // Physical RAM: starts with junk so the zero-fill sweep is observable.
  logic [15:0] mem [0:7];
  initial for (int i = 0; i < 8; i++) mem[i] = 16'hDEAD;
  always @(posedge clk) if (ram_rw) mem[ram_addr] <= ram_din;
  assign ram_dout = mem[ram_addr];

  // Reference model state.
  logic [15:0] ref_mem [0:7];
  logic        model_last = REQ_B;
  logic [15:0] exp_qa [$];
  logic [15:0] exp_qb [$];

  always #5 clk = ~clk;

  ram8x16_arbiter #(.DW(16), .AW(3)) dut (
    .clk(clk), .clr(clr),
    .req_a(req_a), .we_a(we_a), .addr_a(addr_a), .wdata_a(wdata_a),
    .gnt_a(gnt_a), .rvalid_a(rvalid_a), .rdata_a(rdata_a),
    .req_b(req_b), .we_b(we_b), .addr_b(addr_b), .wdata_b(wdata_b),
    .gnt_b(gnt_b), .rvalid_b(rvalid_b), .rdata_b(rdata_b),
    .init_done(init_done), .ram_rw(ram_rw), .ram_addr(ram_addr),
    .ram_din(ram_din), .ram_dout(ram_dout)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Tie winner: the requester that did not win last time, or A under fixed priority.
  function automatic logic tie_pick();
`ifdef RAM_ARB_FIXED_PRIO_EN
    return REQ_A;
`else
    return (model_last == REQ_A) ? REQ_B : REQ_A;
`endif
  endfunction

  task automatic grant_a(input logic w, input logic [2:0] a, input logic [15:0] d);
    if (w) ref_mem[a] = d; else exp_qa.push_back(ref_mem[a]);
    model_last = REQ_A;
  endtask

  task automatic grant_b(input logic w, input logic [2:0] a, input logic [15:0] d);
    if (w) ref_mem[a] = d; else exp_qb.push_back(ref_mem[a]);
    model_last = REQ_B;
  endtask

  // Monitor: read-data scoreboard plus rvalid timing (exactly one cycle after
  // a read grant, unless a reset hit the closing edge).
  logic clr_e = 1'b1;
  logic prv_a = 1'b0, prv_b = 1'b0;
  always @(posedge clk) clr_e <= clr;
  always @(negedge clk) begin
    if (!clr_e) begin exp_qa.delete(); exp_qb.delete(); end
    if (rvalid_a || (prv_a && clr_e)) begin
      chk("rvalid_a timing", rvalid_a, prv_a && clr_e);
      if (rvalid_a) begin
        if (exp_qa.size() == 0) chk("rvalid_a unexpected", 1, 0);
        else chk("rdata_a", rdata_a, exp_qa.pop_front());
      end
    end
    if (rvalid_b || (prv_b && clr_e)) begin
      chk("rvalid_b timing", rvalid_b, prv_b && clr_e);
      if (rvalid_b) begin
        if (exp_qb.size() == 0) chk("rvalid_b unexpected", 1, 0);
        else chk("rdata_b", rdata_b, exp_qb.pop_front());
      end
    end
    prv_a <= gnt_a && !we_a;
    prv_b <= gnt_b && !we_b;
  end

  // Apply reset at the current negedge (one reset edge), check reset values,
  // then wait for the sweep. Optionally A holds a read @0 throughout.
  task automatic do_reset(input bit with_req);
    int n; bit any_g;
    clr = 1'b0; req_a = with_req; we_a = 0; addr_a = 0; wdata_a = 0; req_b = 0;
    @(negedge clk);
    chk("rst init_done", init_done, 0);
    chk("rst gnt", {gnt_a, gnt_b}, 0);
    chk("rst rvalid", {rvalid_a, rvalid_b}, 0);
    chk("rst rdata_a", rdata_a, 0);
    chk("rst rdata_b", rdata_b, 0);
    chk("rst ram_addr", ram_addr, 0);
    chk("rst ram_din", ram_din, 0);
    for (int i = 0; i < 8; i++) ref_mem[i] = 16'h0;
    model_last = REQ_B;
    clr = 1'b1;
    n = 0; any_g = 0;
    do begin
      @(negedge clk); n++;
      any_g |= gnt_a | gnt_b;
    end while (!init_done && n < 20);
    chk("init cycles", n, 8);
    chk("no gnt during init", any_g, 0);
    if (with_req) begin
      // init_done coincides with IDLE, so the held request wins at the next edge.
      @(negedge clk);
      chk("first gnt after init", gnt_a, 1);
      if (gnt_a) grant_a(0, 3'd0, 16'h0);
      req_a = 0;
    end
  endtask

  // One round: A and/or B issue a command together and hold until granted.
  task automatic round(input bit ua, input bit ub, input logic wa, input logic wb,
                       input logic [2:0] aa, input logic [2:0] ab,
                       input logic [15:0] da, input logic [15:0] db);
    int n; bit pa, pb, first; logic exp_w;
    @(negedge clk);
    req_a = ua; we_a = wa; addr_a = aa; wdata_a = da;
    req_b = ub; we_b = wb; addr_b = ab; wdata_b = db;
    pa = ua; pb = ub; first = 1; n = 0;
    exp_w = (ua && ub) ? tie_pick() : (ub ? REQ_B : REQ_A);
    while ((pa || pb) && n < 20) begin
      @(negedge clk); n++;
      if (gnt_a || gnt_b) begin
        chk("gnt onehot", {gnt_a, gnt_b} == 2'b11, 0);
        if (first) begin
          chk("winner", gnt_b, exp_w);
          if (!(ua && ub)) chk("gnt latency", n, 1);
          first = 0;
        end
        if (gnt_a) begin chk("gnt_a requested", pa, 1); grant_a(wa, aa, da); pa = 0; req_a = 0; end
        if (gnt_b) begin chk("gnt_b requested", pb, 1); grant_b(wb, ab, db); pb = 0; req_b = 0; end
      end
    end
    if (pa || pb) begin chk("round timeout", 1, 0); req_a = 0; req_b = 0; end
  endtask

  initial begin
    int n;
    // Reset with A requesting during the sweep.
    do_reset(1);
    // Every word reads back zero after the sweep.
    for (int i = 0; i < 8; i++) round(1, 0, 0, 0, 3'(i), 0, 0, 0);
    // Write / read back by A; B's read register stays untouched.
    round(1, 0, 1, 0, 3'd3, 0, 16'hBEEF, 0);
    round(1, 0, 0, 0, 3'd3, 0, 0, 0);
    @(negedge clk);
    chk("rdata_a beef", rdata_a, 16'hBEEF);
    chk("rdata_b untouched", rdata_b, 16'h0);
    round(0, 1, 0, 0, 0, 3'd3, 0, 0);
    // Reset hitting the closing edge of B's read: access aborted, sweep re-zeros.
    @(negedge clk);
    req_b = 1; we_b = 0; addr_b = 3'd3;
    n = 0;
    do begin @(negedge clk); n++; end while (!gnt_b && n < 6);
    chk("abort gnt_b", gnt_b, 1);
    do_reset(0);
    round(1, 0, 0, 0, 3'd3, 0, 0, 0);
    // Fresh reset, then both hold requests continuously.
    @(negedge clk);
    do_reset(0);
    @(negedge clk);
    req_a = 1; we_a = 1; addr_a = 3'd1; wdata_a = 16'h1111;
    req_b = 1; we_b = 0; addr_b = 3'd1;
    for (int k = 0; k < 8; k++) begin
      n = 0;
      do begin @(negedge clk); n++; end while (!(gnt_a || gnt_b) && n < 6);
      if (!(gnt_a || gnt_b)) begin chk("held timeout", 1, 0); break; end
      chk("held winner", gnt_b, tie_pick());
      if (gnt_a) grant_a(1, 3'd1, 16'h1111); else grant_b(0, 3'd1, 0);
    end
    req_a = 0;
    n = 0;
    do begin @(negedge clk); n++; end while (!gnt_b && n < 6);
    chk("gnt_b after A drops", gnt_b, 1);
    if (gnt_b) grant_b(0, 3'd1, 0);
    req_b = 0;
    // Randomised mix of single and contended rounds.
    for (int r = 0; r < 30; r++) begin
      int sel;
      sel = $urandom_range(1, 3);
      round(sel[0], sel[1], 1'($urandom), 1'($urandom), 3'($urandom), 3'($urandom),
            16'($urandom), 16'($urandom));
    end
    repeat (4) @(negedge clk);
    chk("scoreboard drained", exp_qa.size() + exp_qb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule
